// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles the decode slice's buses: fetch-stage inputs (f_*), write-back
//   inputs from the W stage (w_*), the D-register and E-register contents
//   (d_*, e_*), the combinational register reads (d_valA/d_valB) and the
//   live register-file contents (reg_mem0..reg_mem14).
//   master : the surrounding pipeline (drives f_*/w_*, observes the rest)
//   slave  : decode_stage (consumes f_*/w_*, drives d_*/e_*/reg_mem*)
interface decode_stage_if #(
    parameter int DATA_W = 64
);
    logic [2:0]        f_stat;
    logic [3:0]        f_icode, f_ifun, f_rA, f_rB;
    logic [DATA_W-1:0] f_valC, f_valP;

    logic [3:0]        w_icode, w_rA, w_rB;
    logic              w_cnd;
    logic [DATA_W-1:0] w_valE, w_valM;

    logic [2:0]        d_stat;
    logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
    logic [DATA_W-1:0] d_valC, d_valP, d_valA, d_valB;

    logic [2:0]        e_stat;
    logic [3:0]        e_icode, e_ifun, e_rA, e_rB;
    logic [DATA_W-1:0] e_valC, e_valP, e_valA, e_valB;

    logic [DATA_W-1:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
    logic [DATA_W-1:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
    logic [DATA_W-1:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;

    modport master (
        output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
        input  d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
        input  e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
        input  reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
        input  reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
        input  reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
    );

    modport slave (
        input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
        output d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
        output e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
        output reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
        output reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
        output reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Y86-64 decode slice: F->D pipeline register, 15 x DATA_W register file
//   (two combinational decode reads, two write-back write ports) and D->E
//   pipeline register. No stall, bubble or forwarding from E/M.
// Ports
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset (D/E regs -> nop bubble, regs -> 0)
//   bus  : decode_stage_if.slave (f_* / w_* in; d_*, e_*, reg_mem* out)
// Parameters
//   DATA_W  : datapath / register width
//   RSP_IDX : register id of %rsp
// Configuration
//   WB_BYPASS_EN : when defined, a decode read whose source matches a
//   same-cycle write-back destination returns the write-back value
//   (valM before valE). Undefined: reads see stored contents only.
module decode_stage #(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] RSP_IDX = 4'd4
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;

    logic [DATA_W-1:0] rf [0:14];

    logic [2:0]        stat_p0, stat_p1;
    logic [3:0]        icode_p0, ifun_p0, ra_p0, rb_p0;
    logic [3:0]        icode_p1, ifun_p1, ra_p1, rb_p1;
    logic [DATA_W-1:0] valc_p0, valp_p0;
    logic [DATA_W-1:0] valc_p1, valp_p1, vala_p1, valb_p1;

    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] val_a, val_b;

    function automatic logic [3:0] sel_src_a(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: return ra;
            4'h9, 4'hB:             return RSP_IDX;
            default:                return RNONE;
        endcase
    endfunction

    function automatic logic [3:0] sel_src_b(input logic [3:0] icode, input logic [3:0] rb);
        case (icode)
            4'h4, 4'h5, 4'h6:       return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return RSP_IDX;
            default:                return RNONE;
        endcase
    endfunction

    // cmovXX (icode 2) only commits when its condition held.
    function automatic logic [3:0] sel_dst_e(input logic [3:0] icode, input logic [3:0] rb,
                                             input logic cnd);
        case (icode)
            4'h2:                   return cnd ? rb : RNONE;
            4'h3, 4'h6:             return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return RSP_IDX;
            default:                return RNONE;
        endcase
    endfunction

    function automatic logic [3:0] sel_dst_m(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            4'h5, 4'hB: return ra;
            default:    return RNONE;
        endcase
    endfunction

    always_comb begin
        src_a = sel_src_a(icode_p0, ra_p0);
        src_b = sel_src_b(icode_p0, rb_p0);
        dst_e = sel_dst_e(bus.w_icode, bus.w_rB, bus.w_cnd);
        dst_m = sel_dst_m(bus.w_icode, bus.w_rA);
    end

    // Decode reads; id F reads as zero and never indexes the array.
    always_comb begin
        val_a = '0;
        val_b = '0;
        if (src_a != RNONE) val_a = rf[src_a];
        if (src_b != RNONE) val_b = rf[src_b];
`ifdef WB_BYPASS_EN
        if (src_a != RNONE) begin
            if (src_a == dst_m)      val_a = bus.w_valM;
            else if (src_a == dst_e) val_a = bus.w_valE;
        end
        if (src_b != RNONE) begin
            if (src_b == dst_m)      val_b = bus.w_valM;
            else if (src_b == dst_e) val_b = bus.w_valE;
        end
`endif
    end

    // Write-back; the M write is issued last so popq %rsp keeps valM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else begin
            if (dst_e != RNONE) rf[dst_e] <= bus.w_valE;
            if (dst_m != RNONE) rf[dst_m] <= bus.w_valM;
        end
    end

    // ---- F -> D boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_p0  <= 3'b001;
            icode_p0 <= 4'h1;
            ifun_p0  <= 4'h0;
            ra_p0    <= RNONE;
            rb_p0    <= RNONE;
            valc_p0  <= '0;
            valp_p0  <= '0;
        end else begin
            stat_p0  <= bus.f_stat;
            icode_p0 <= bus.f_icode;
            ifun_p0  <= bus.f_ifun;
            ra_p0    <= bus.f_rA;
            rb_p0    <= bus.f_rB;
            valc_p0  <= bus.f_valC;
            valp_p0  <= bus.f_valP;
        end
    end

    // ---- D -> E boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_p1  <= 3'b001;
            icode_p1 <= 4'h1;
            ifun_p1  <= 4'h0;
            ra_p1    <= RNONE;
            rb_p1    <= RNONE;
            valc_p1  <= '0;
            valp_p1  <= '0;
            vala_p1  <= '0;
            valb_p1  <= '0;
        end else begin
            stat_p1  <= stat_p0;
            icode_p1 <= icode_p0;
            ifun_p1  <= ifun_p0;
            ra_p1    <= ra_p0;
            rb_p1    <= rb_p0;
            valc_p1  <= valc_p0;
            valp_p1  <= valp_p0;
            vala_p1  <= val_a;
            valb_p1  <= val_b;
        end
    end

    assign bus.d_stat  = stat_p0;
    assign bus.d_icode = icode_p0;
    assign bus.d_ifun  = ifun_p0;
    assign bus.d_rA    = ra_p0;
    assign bus.d_rB    = rb_p0;
    assign bus.d_valC  = valc_p0;
    assign bus.d_valP  = valp_p0;
    assign bus.d_valA  = val_a;
    assign bus.d_valB  = val_b;

    assign bus.e_stat  = stat_p1;
    assign bus.e_icode = icode_p1;
    assign bus.e_ifun  = ifun_p1;
    assign bus.e_rA    = ra_p1;
    assign bus.e_rB    = rb_p1;
    assign bus.e_valC  = valc_p1;
    assign bus.e_valP  = valp_p1;
    assign bus.e_valA  = vala_p1;
    assign bus.e_valB  = valb_p1;

    assign bus.reg_mem0  = rf[0];
    assign bus.reg_mem1  = rf[1];
    assign bus.reg_mem2  = rf[2];
    assign bus.reg_mem3  = rf[3];
    assign bus.reg_mem4  = rf[4];
    assign bus.reg_mem5  = rf[5];
    assign bus.reg_mem6  = rf[6];
    assign bus.reg_mem7  = rf[7];
    assign bus.reg_mem8  = rf[8];
    assign bus.reg_mem9  = rf[9];
    assign bus.reg_mem10 = rf[10];
    assign bus.reg_mem11 = rf[11];
    assign bus.reg_mem12 = rf[12];
    assign bus.reg_mem13 = rf[13];
    assign bus.reg_mem14 = rf[14];
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Scoreboard bench for decode_stage. Each cycle the expected D and E
//   contents are pushed when stimulus is driven and popped after the edge.
//   A small reference model of the register file supplies read values.
module tb_decode_stage;
    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, vala, valb;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(64)) bus ();

    decode_stage #(.DATA_W(64), .RSP_IDX(4'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [63:0] rm [0:14];
    assign rm[0]  = bus.reg_mem0;
    assign rm[1]  = bus.reg_mem1;
    assign rm[2]  = bus.reg_mem2;
    assign rm[3]  = bus.reg_mem3;
    assign rm[4]  = bus.reg_mem4;
    assign rm[5]  = bus.reg_mem5;
    assign rm[6]  = bus.reg_mem6;
    assign rm[7]  = bus.reg_mem7;
    assign rm[8]  = bus.reg_mem8;
    assign rm[9]  = bus.reg_mem9;
    assign rm[10] = bus.reg_mem10;
    assign rm[11] = bus.reg_mem11;
    assign rm[12] = bus.reg_mem12;
    assign rm[13] = bus.reg_mem13;
    assign rm[14] = bus.reg_mem14;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mdl_rf [0:14];
    rec_t        mdl_d;
    rec_t        d_q [$];
    rec_t        e_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic rec_t reset_rec();
        rec_t r;
        r = '0;
        r.stat  = 3'b001;
        r.icode = 4'h1;
        r.ra    = 4'hF;
        r.rb    = 4'hF;
        return r;
    endfunction

    function automatic rec_t frec(input logic [3:0] icode, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic [63:0] valc);
        rec_t r;
        r = '0;
        r.stat  = 3'b001;
        r.icode = icode;
        r.ifun  = 4'h0;
        r.ra    = ra;
        r.rb    = rb;
        r.valc  = valc;
        r.valp  = valc + 64'd10;
        return r;
    endfunction

    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
        if (ic == 4'h9 || ic == 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 4'h5 || ic == 4'hB) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src);
        logic [3:0] de, dm;
        de = m_dst_e(bus.w_icode, bus.w_rB, bus.w_cnd);
        dm = m_dst_m(bus.w_icode, bus.w_rA);
        if (src == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
        if (src == dm) return bus.w_valM;
        if (src == de) return bus.w_valE;
`endif
        return mdl_rf[src];
    endfunction

    // One clock: drive at negedge, check combinational reads before the
    // edge, update the model, then compare registered state after the edge.
    task automatic cycle(input logic r, input rec_t f, input logic [3:0] wi,
                         input logic [3:0] wra, input logic [3:0] wrb, input logic wc,
                         input logic [63:0] ve, input logic [63:0] vm);
        rec_t ed, ee, gd, ge;
        logic [3:0] de, dm;
        @(negedge clk);
        rst = r;
        bus.f_stat = f.stat;  bus.f_icode = f.icode; bus.f_ifun = f.ifun;
        bus.f_rA = f.ra;      bus.f_rB = f.rb;
        bus.f_valC = f.valc;  bus.f_valP = f.valp;
        bus.w_icode = wi; bus.w_rA = wra; bus.w_rB = wrb; bus.w_cnd = wc;
        bus.w_valE = ve;  bus.w_valM = vm;
        #1;
        ee = reset_rec();
        ed = reset_rec();
        if (!r) begin
            ee = mdl_d;
            ee.vala = m_read(m_src_a(mdl_d.icode, mdl_d.ra));
            ee.valb = m_read(m_src_b(mdl_d.icode, mdl_d.rb));
            check("d_valA_pre", bus.d_valA, ee.vala);
            check("d_valB_pre", bus.d_valB, ee.valb);
            ed = f;
        end
        e_q.push_back(ee);
        d_q.push_back(ed);
        if (r) begin
            for (int i = 0; i < 15; i++) mdl_rf[i] = 64'd0;
        end else begin
            de = m_dst_e(wi, wrb, wc);
            dm = m_dst_m(wi, wra);
            if (de != 4'hF) mdl_rf[de] = ve;
            if (dm != 4'hF) mdl_rf[dm] = vm;
        end
        mdl_d = ed;
        @(posedge clk);
        #1;
        gd = d_q.pop_front();
        ge = e_q.pop_front();
        check("d_stat",  {61'd0, bus.d_stat}, {61'd0, gd.stat});
        check("d_icode", {60'd0, bus.d_icode}, {60'd0, gd.icode});
        check("d_ifun",  {60'd0, bus.d_ifun}, {60'd0, gd.ifun});
        check("d_rA",    {60'd0, bus.d_rA}, {60'd0, gd.ra});
        check("d_rB",    {60'd0, bus.d_rB}, {60'd0, gd.rb});
        check("d_valC",  bus.d_valC, gd.valc);
        check("d_valP",  bus.d_valP, gd.valp);
        check("e_stat",  {61'd0, bus.e_stat}, {61'd0, ge.stat});
        check("e_icode", {60'd0, bus.e_icode}, {60'd0, ge.icode});
        check("e_ifun",  {60'd0, bus.e_ifun}, {60'd0, ge.ifun});
        check("e_rA",    {60'd0, bus.e_rA}, {60'd0, ge.ra});
        check("e_rB",    {60'd0, bus.e_rB}, {60'd0, ge.rb});
        check("e_valC",  bus.e_valC, ge.valc);
        check("e_valP",  bus.e_valP, ge.valp);
        check("e_valA",  bus.e_valA, ge.vala);
        check("e_valB",  bus.e_valB, ge.valb);
        for (int i = 0; i < 15; i++)
            check($sformatf("reg_mem%0d", i), rm[i], mdl_rf[i]);
    endtask

    rec_t nop;
    rec_t rf_in;

    initial begin
        nop = frec(4'h1, 4'hF, 4'hF, 64'd0);
        mdl_d = reset_rec();
        for (int i = 0; i < 15; i++) mdl_rf[i] = 64'd0;
        bus.f_stat = 3'b001; bus.f_icode = 4'h1; bus.f_ifun = 4'h0;
        bus.f_rA = 4'hF; bus.f_rB = 4'hF; bus.f_valC = '0; bus.f_valP = '0;
        bus.w_icode = 4'h1; bus.w_rA = 4'hF; bus.w_rB = 4'hF; bus.w_cnd = 1'b0;
        bus.w_valE = '0; bus.w_valM = '0;

        // Reset state
        cycle(1'b1, nop, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        cycle(1'b1, nop, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        check("rst_d_icode", {60'd0, bus.d_icode}, 64'd1);
        check("rst_e_stat",  {61'd0, bus.e_stat}, 64'd1);

        // irmovq-style write of reg 2, then rrmovq reads it
        cycle(1'b0, nop, 4'h3, 4'hF, 4'h2, 1'b0, 64'd42, 64'd0);
        check("wb_reg2", rm[2], 64'd42);
        cycle(1'b0, frec(4'h6, 4'h2, 4'hF, 64'd0), 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        check("rd_d_valA", bus.d_valA, 64'd42);
        cycle(1'b0, nop, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        check("rd_e_valA", bus.e_valA, 64'd42);

        // cmov not taken / taken
        cycle(1'b0, nop, 4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0);
        check("cmov_nt", rm[3], 64'd0);
        cycle(1'b0, nop, 4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'd0);
        check("cmov_t", rm[3], 64'd7);

        // popq %rsp: valM beats valE on the same register
        cycle(1'b0, nop, 4'hB, 4'h4, 4'hF, 1'b0, 64'd16, 64'd99);
        check("popq_rsp", rm[4], 64'd99);

        // Stack-pointer reads
        cycle(1'b0, nop, 4'h3, 4'hF, 4'h4, 1'b0, 64'd128, 64'd0);
        cycle(1'b0, frec(4'h9, 4'hF, 4'hF, 64'd0), 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        check("stk_valA", bus.d_valA, 64'd128);
        check("stk_valB", bus.d_valB, 64'd128);

        // Same-cycle write of reg 1 while D reads it (model covers bypass)
        cycle(1'b0, frec(4'h2, 4'h1, 4'hF, 64'd0), 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        cycle(1'b0, nop, 4'h3, 4'hF, 4'h1, 1'b0, 64'd5, 64'd0);
        check("byp_e_valA", bus.e_valA,
`ifdef WB_BYPASS_EN
              64'd5
`else
              64'd0
`endif
        );

        // Unknown icodes: nothing read or written, fields still flow
        cycle(1'b0, frec(4'hC, 4'h2, 4'h3, 64'h55), 4'hD, 4'h2, 4'h3, 1'b1, 64'd1, 64'd2);
        cycle(1'b0, nop, 4'hE, 4'h5, 4'h6, 1'b1, 64'd3, 64'd4);
        check("unk_reg2", rm[2], 64'd42);

        // Reset in the middle wins over a pending write-back
        cycle(1'b1, nop, 4'h3, 4'hF, 4'h5, 1'b0, 64'd77, 64'd0);
        check("rst_wins", rm[5], 64'd0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            rf_in = frec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), {$urandom, $urandom});
            rf_in.ifun = 4'($urandom_range(0, 15));
            rf_in.stat = 3'(1 << $urandom_range(0, 2));
            cycle(1'b0, rf_in, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        cycle(1'b0, nop, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        cycle(1'b0, nop, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
